frame_window_packer: RTL and testbench
======================================

Name: frame_window_packer

Overview:
Downstream capture stage for the sprite/VGA pixel stream. It watches the 2-bit pixel at each (row, column) scan position and captures one full frame inside a rectangular window. Every 16 pixels are packed into a 32-bit word, and words are buffered in a small FIFO. A ready/valid port drains the FIFO to a host, such as a UART dumper or an image-file writer in simulation.

Parameters:
WIN_X0, 16, first captured column
WIN_Y0, 0, first captured row
WIN_W, 256, window width in pixels; must be a multiple of 16
WIN_H, 256, window height in rows
FIFO_DEPTH, 8, word FIFO entries; power of 2, at least 2

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Row  in  10  current scan row
i_Column  in  10  current scan column
i_Pixel  in  2  pixel value at (i_Row, i_Column)
i_Pixel_Valid  in  1  scan position and pixel are meaningful this cycle
i_Arm  in  1  one-cycle request to capture the next frame
o_Word  out  32  FIFO head word
o_Word_Valid  out  1  FIFO non-empty
i_Word_Ready  in  1  consumer accepts o_Word this cycle
o_Busy  out  1  state is WAIT_SOF or CAPTURE
o_Frame_Done  out  1  one-cycle pulse when the final word of the frame is pushed
o_Overflow  out  1  sticky flag: a word was dropped because the FIFO was full
o_Word_Count  out  16  words pushed (or dropped) in the current capture

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - state = IDLE; shift register, pixel counter and word count = 0
  - FIFO emptied; o_Word_Valid = 0; o_Word = 0
  - o_Busy = 0; o_Frame_Done = 0; o_Overflow = 0
- Reset mid-capture aborts the capture; no partial word is pushed.
- in_win = i_Pixel_Valid && WIN_Y0 <= i_Row < WIN_Y0+WIN_H && WIN_X0 <= i_Column < WIN_X0+WIN_W. Comparisons are on unsigned 11-bit sums, so there is no wrap.
- State machine:
  - IDLE: i_Arm → WAIT_SOF. On arming, clear o_Overflow, word count and pixel counter.
  - WAIT_SOF: stays until in_win with i_Row == WIN_Y0 and i_Column == WIN_X0, then → CAPTURE. That pixel is captured in the same cycle. Mid-frame pixels are ignored, so capture always starts at a frame origin.
  - CAPTURE: each in_win cycle shifts sr <= {sr[29:0], i_Pixel}. The first pixel of a word lands in bits [31:30].
    - A 4-bit pixel counter wraps after 16 pixels.
    - On the 16th pixel, the completed word {sr[29:0], i_Pixel} is pushed that same cycle. The word includes the 16th pixel.
    - Word count increments on every completed word, whether pushed or dropped.
  - When the completed word is number WIN_W*WIN_H/16 (4096 with defaults): pulse o_Frame_Done for one cycle and → IDLE.
  - i_Arm while o_Busy is ignored.
- Cycles with out-of-window or invalid positions leave the shift register and counter unchanged. Blanking gaps are therefore transparent.
- FIFO behaviour:
  - First-word fall-through. o_Word is the head entry whenever o_Word_Valid = 1.
  - A pop happens when o_Word_Valid && i_Word_Ready.
  - A pushed word becomes visible at the output on the next cycle, giving 1-cycle latency from completion to o_Word_Valid.
  - Push when full without a simultaneous pop: the word is dropped, o_Overflow is set and stays set until reset or the next arm, and counting continues.
  - Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle when empty: the pop is not possible (o_Word_Valid = 0); the push succeeds.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits, with a wrap bit distinguishing full from empty.
- The output side keeps draining in IDLE after the capture ends.
- o_Word holds its value while o_Word_Valid is low.

Test Plan:
1. Reset, then arm; scan pixel i = column & 3 over a 256x256 window (column 16 to 271, rows 0 to 255), with i_Word_Ready = 1.
   → First word is 0x1B1B1B1B (pixel sequence 0,1,2,3…). 4096 words total. o_Frame_Done pulses exactly once; o_Overflow = 0; o_Word_Count = 4096.
2. Arm mid-frame, with first in_win at row 10.
   → Nothing is captured until row 0, column 16 of the next frame. The first word is then built from that pixel onward.
3. Hold i_Word_Ready = 0 throughout.
   → Exactly 8 words are stored. Word 9 is dropped and o_Overflow = 1. Releasing ready yields words 1 to 8 in order. o_Frame_Done still pulses at count 4096.
4. FIFO full while ready toggles so that pop and push coincide.
   → No drop, o_Overflow stays 0, and the word sequence is contiguous.
5. Interleave i_Pixel_Valid = 0 cycles and out-of-window columns within a word.
   → Packed words are identical to those from scenario 1.
6. Assert i_Reset asynchronously mid-word (between clock edges, 7 pixels into a word) during CAPTURE.
   → All outputs go to their reset values immediately, with no partial push. A re-arm gives a clean capture.

Source files
------------

// File: rtl/frame_window_packer.sv
// Captures one frame of 2-bit pixels inside a rectangular scan window, packs 16 pixels
// per 32-bit word and buffers the words in a first-word-fall-through FIFO for a host.
module frame_window_packer #(
    parameter int WIN_X0     = 16,
    parameter int WIN_Y0     = 0,
    parameter int WIN_W      = 256,
    parameter int WIN_H      = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [9:0]  i_Row,
    input  logic [9:0]  i_Column,
    input  logic [1:0]  i_Pixel,
    input  logic        i_Pixel_Valid,
    input  logic        i_Arm,
    output logic [31:0] o_Word,
    output logic        o_Word_Valid,
    input  logic        i_Word_Ready,
    output logic        o_Busy,
    output logic        o_Frame_Done,
    output logic        o_Overflow,
    output logic [15:0] o_Word_Count
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] FRAME_WORDS = 16'(WIN_W * WIN_H / 16);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;

    logic [1:0]  state;
    logic [31:0] sr;
    logic [3:0]  pix_cnt;
    logic [15:0] word_count;
    logic        frame_done;
    logic        overflow;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] hold_word;

    // An 11-bit offset below the window origin underflows to >= 1025, so a single
    // unsigned compare covers both window edges without wrap.
    logic [10:0] row_off;
    logic [10:0] col_off;
    logic        in_win;
    logic        sof;

    assign row_off = {1'b0, i_Row} - 11'(WIN_Y0);
    assign col_off = {1'b0, i_Column} - 11'(WIN_X0);
    assign in_win  = i_Pixel_Valid && (row_off < 11'(WIN_H)) && (col_off < 11'(WIN_W));
    assign sof     = in_win && (i_Row == 10'(WIN_Y0)) && (i_Column == 10'(WIN_X0));

    logic        shift_en;
    logic        word_done;
    logic        last_word;
    logic [31:0] packed_word;

    assign shift_en    = ((state == ST_CAPTURE) && in_win) || ((state == ST_WAIT_SOF) && sof);
    assign word_done   = shift_en && (pix_cnt == 4'hF);
    assign packed_word = {sr[29:0], i_Pixel};
    assign last_word   = word_done && (word_count == FRAME_WORDS - 16'd1);

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && i_Word_Ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign push       = word_done && (!fifo_full || pop);
    assign drop       = word_done && fifo_full && !pop;

    // NOTE: sequential state uses non-blocking (<=) assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= ST_IDLE;
            sr         <= '0;
            pix_cnt    <= '0;
            word_count <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= last_word;
            case (state)
                ST_IDLE: begin
                    if (i_Arm) begin
                        state      <= ST_WAIT_SOF;
                        overflow   <= 1'b0;
                        word_count <= '0;
                        pix_cnt    <= '0;
                    end
                end
                ST_WAIT_SOF: if (sof) state <= ST_CAPTURE;
                ST_CAPTURE:  if (last_word) state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
            if (shift_en) begin
                sr      <= packed_word;
                pix_cnt <= pix_cnt + 4'd1;
            end
            if (word_done) word_count <= word_count + 16'd1;
            if (drop)      overflow   <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_word <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                hold_word <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers define which entries are
    // valid, and hold_word supplies the reset/held value of o_Word while empty.
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= packed_word;
    end

    assign o_Word       = fifo_empty ? hold_word : mem[rd_ptr[AW-1:0]];
    assign o_Word_Valid = !fifo_empty;
    assign o_Busy       = (state != ST_IDLE);
    assign o_Frame_Done = frame_done;
    assign o_Overflow   = overflow;
    assign o_Word_Count = word_count;

endmodule

// File: tb/tb_frame_window_packer.sv
// Scoreboard bench for frame_window_packer: stimulus queues expected words, a monitor
// pops and compares each word the DUT hands over. Uses a reduced window to stay short.
module tb_frame_window_packer;

    localparam int X0    = 4;
    localparam int Y0    = 2;
    localparam int W     = 32;
    localparam int H     = 6;
    localparam int DEPTH = 8;
    localparam int ROWS  = 10;
    localparam int COLS  = 40;
    localparam int NWORD = W * H / 16;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic [9:0]  i_Row = '0;
    logic [9:0]  i_Column = '0;
    logic [1:0]  i_Pixel = '0;
    logic        i_Pixel_Valid = 1'b0;
    logic        i_Arm = 1'b0;
    logic [31:0] o_Word;
    logic        o_Word_Valid;
    logic        i_Word_Ready = 1'b0;
    logic        o_Busy;
    logic        o_Frame_Done;
    logic        o_Overflow;
    logic [15:0] o_Word_Count;

    frame_window_packer #(
        .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Row(i_Row), .i_Column(i_Column),
        .i_Pixel(i_Pixel), .i_Pixel_Valid(i_Pixel_Valid), .i_Arm(i_Arm),
        .o_Word(o_Word), .o_Word_Valid(o_Word_Valid), .i_Word_Ready(i_Word_Ready),
        .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Overflow(o_Overflow),
        .o_Word_Count(o_Word_Count)
    );

    always #5 i_Clk = ~i_Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    int          got_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] first_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pix(input int f, input int r, input int c);
        if (f == 0) return 2'(c & 3);
        return 2'(((c >> 1) + r + f) & 3);
    endfunction

    function automatic logic [31:0] exp_word(input int f, input int k);
        logic [31:0] w = '0;
        for (int i = 0; i < 16; i++) begin
            int p = k * 16 + i;
            w = {w[29:0], pix(f, Y0 + p / W, X0 + p % W)};
        end
        return w;
    endfunction

    task automatic push_exp(input int f, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_word(f, k));
    endtask

    // Monitor: sampled on the falling edge, a handshake here is a pop on the next rise.
    always @(negedge i_Clk) begin
        if (!i_Reset) begin
            if (o_Frame_Done) done_cnt++;
            if (o_Word_Valid && i_Word_Ready) begin
                got_cnt++;
                if (got_cnt == 1) first_word = o_Word;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %h expected none at %0t", o_Word, $time);
                end else begin
                    check("word", o_Word, exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic v, input int r, input int c, input logic [1:0] p);
        i_Pixel_Valid = v;
        i_Row         = 10'(r);
        i_Column      = 10'(c);
        i_Pixel       = p;
        @(posedge i_Clk);
        #1;
        i_Arm = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 2'd0);
    endtask

    task automatic arm();
        i_Arm = 1'b1;
        idle(1);
    endtask

    // rmode: 0 ready high, 1 ready low, 2 ready only on word-completing pixels once full.
    task automatic scan(input int f, input int start_row, input bit bubbles, input int rmode,
                        input int abort_at, input bit arm_mid);
        int cap = 0;
        for (int r = start_row; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bit inw = (r >= Y0) && (r < Y0 + H) && (c >= X0) && (c < X0 + W);
                i_Word_Ready = (rmode == 0);
                if (bubbles && inw && (c % 5 == 0)) cyc(1'b0, r, c, ~pix(f, r, c));
                if (rmode == 2) i_Word_Ready = inw && (cap % 16 == 15) && (cap >= 16 * DEPTH);
                if (arm_mid && inw && cap == 40) i_Arm = 1'b1;
                cyc(1'b1, r, c, pix(f, r, c));
                if (inw) begin
                    cap++;
                    if (cap == abort_at) return;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        i_Word_Ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        check(name, 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_before;
        #1;
        idle(2);
        check("rst_valid", 32'(o_Word_Valid), 32'd0);
        check("rst_word", o_Word, 32'd0);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Frame_Done), 32'd0);
        check("rst_ovf", 32'(o_Overflow), 32'd0);
        check("rst_count", 32'(o_Word_Count), 32'd0);
        i_Reset = 1'b0;
        idle(2);

        // Frame with pixel = column & 3, host always ready.
        arm();
        check("s1_busy", 32'(o_Busy), 32'd1);
        got_cnt = 0;
        done_before = done_cnt;
        push_exp(0, NWORD);
        scan(0, 0, 1'b0, 0, -1, 1'b0);
        drain("s1_drain");
        check("s1_first", first_word, 32'h1B1B1B1B);
        check("s1_words", 32'(got_cnt), 32'(NWORD));
        check("s1_done", 32'(done_cnt - done_before), 32'd1);
        check("s1_ovf", 32'(o_Overflow), 32'd0);
        check("s1_count", 32'(o_Word_Count), 32'(NWORD));
        check("s1_idle", 32'(o_Busy), 32'd0);

        // Arm mid-frame: capture must wait for the next frame origin.
        arm();
        got_cnt = 0;
        done_before = done_cnt;
        scan(1, 4, 1'b0, 0, -1, 1'b0);
        check("s2_wait_busy", 32'(o_Busy), 32'd1);
        check("s2_wait_count", 32'(o_Word_Count), 32'd0);
        push_exp(2, NWORD);
        scan(2, 0, 1'b0, 0, -1, 1'b0);
        drain("s2_drain");
        check("s2_first", first_word, 32'hAF05AF05);
        check("s2_done", 32'(done_cnt - done_before), 32'd1);

        // Host stalled for the whole frame: 8 stored, the rest dropped.
        arm();
        got_cnt = 0;
        done_before = done_cnt;
        push_exp(3, DEPTH);
        scan(3, 0, 1'b0, 1, -1, 1'b0);
        check("s3_ovf", 32'(o_Overflow), 32'd1);
        check("s3_count", 32'(o_Word_Count), 32'(NWORD));
        check("s3_done", 32'(done_cnt - done_before), 32'd1);
        check("s3_valid", 32'(o_Word_Valid), 32'd1);
        drain("s3_drain");
        check("s3_words", 32'(got_cnt), 32'(DEPTH));
        i_Word_Ready = 1'b0;
        idle(3);
        check("s3_empty", 32'(o_Word_Valid), 32'd0);
        check("s3_hold", o_Word, exp_word(3, DEPTH - 1));

        // Full FIFO with pop coinciding with push: nothing dropped.
        arm();
        check("s4_ovf_clr", 32'(o_Overflow), 32'd0);
        got_cnt = 0;
        push_exp(4, NWORD);
        scan(4, 0, 1'b0, 2, -1, 1'b0);
        check("s4_ovf", 32'(o_Overflow), 32'd0);
        drain("s4_drain");
        check("s4_words", 32'(got_cnt), 32'(NWORD));

        // Invalid bubbles inside the window plus an ignored arm while busy.
        arm();
        got_cnt = 0;
        done_before = done_cnt;
        push_exp(5, NWORD);
        scan(5, 0, 1'b1, 0, -1, 1'b1);
        drain("s5_drain");
        check("s5_words", 32'(got_cnt), 32'(NWORD));
        check("s5_count", 32'(o_Word_Count), 32'(NWORD));
        check("s5_done", 32'(done_cnt - done_before), 32'd1);

        // Asynchronous reset seven pixels into the second word.
        arm();
        done_before = done_cnt;
        push_exp(6, 1);
        scan(6, 0, 1'b0, 0, 23, 1'b0);
        #2;
        i_Reset = 1'b1;
        #1;
        check("s6_valid", 32'(o_Word_Valid), 32'd0);
        check("s6_word", o_Word, 32'd0);
        check("s6_busy", 32'(o_Busy), 32'd0);
        check("s6_count", 32'(o_Word_Count), 32'd0);
        check("s6_word0_seen", 32'(exp_q.size()), 32'd0);
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
        i_Word_Ready = 1'b1;
        idle(10);
        check("s6_no_partial", 32'(o_Word_Valid), 32'd0);
        check("s6_no_done", 32'(done_cnt - done_before), 32'd0);
        arm();
        got_cnt = 0;
        push_exp(7, NWORD);
        scan(7, 0, 1'b0, 0, -1, 1'b0);
        drain("s6_drain");
        check("s6_words", 32'(got_cnt), 32'(NWORD));
        check("s6_done", 32'(done_cnt - done_before), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
